// File: rtl/fixed_point_adder_arbiter.sv
// Round-robin front end that shares one sign-magnitude adder among NUM_REQ requesters.
// Each result goes into a single response slot, tagged with the requester ID and an overflow flag.

module fixed_point_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);
    // A zero-magnitude result from opposite-sign operands becomes +0. Same-sign zeros keep their sign.
    always_comb begin
        sum = '0;
        if (a[N-1] == b[N-1])
            sum = {a[N-1], a[N-2:0] + b[N-2:0]};
        else if (a[N-2:0] > b[N-2:0])
            sum = {a[N-1], a[N-2:0] - b[N-2:0]};
        else if (a[N-2:0] < b[N-2:0])
            sum = {b[N-1], b[N-2:0] - a[N-2:0]};
        else
            sum = '0;
    end
endmodule

module fixed_point_adder_arbiter #(
    parameter int N       = 32,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [N-1:0]         rsp_sum,
    output logic                 rsp_ovf
);
    localparam logic [0:0]         EMPTY = 1'b0;
    localparam logic [0:0]         FULL  = 1'b1;
    localparam logic [NUM_REQ-1:0] ONE   = NUM_REQ'(1);

    logic [0:0]      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_idx;
    logic            grant_any;
    logic            slot_free;
    logic            issue_p0;
    logic [N-1:0]    a_p0;
    logic [N-1:0]    b_p0;
    logic [N-1:0]    sum_p0;
    logic [ID_W:0]   idx_ext;
    logic [ID_W-1:0] idx;

    // A same-sign add overflows when the magnitude carries out past N-1 bits.
    function automatic logic mag_ovf(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] m;
        m = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
        return (a[N-1] == b[N-1]) && m[N-1];
    endfunction

    // Scan from the highest offset down, so the last match is the first valid index at or after rr_ptr.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx_ext   = '0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_ext = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx_ext >= (ID_W+1)'(NUM_REQ))
                idx_ext = idx_ext - (ID_W+1)'(NUM_REQ);
            idx = idx_ext[ID_W-1:0];
            if (req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
    end

    assign slot_free = (state == EMPTY) || rsp_ready;
    assign issue_p0  = rst_n && slot_free && grant_any;
    assign req_ready = issue_p0 ? (ONE << grant_idx) : '0;
    assign rsp_valid = (state == FULL);

    // Issue stage: operands of the granted requester feed the shared adder.
    assign a_p0 = req_a[grant_idx*N +: N];
    assign b_p0 = req_b[grant_idx*N +: N];

    fixed_point_adder #(.N(N)) u_adder (
        .a   (a_p0),
        .b   (b_p0),
        .sum (sum_p0)
    );

    // Response stage: the slot reloads on any issue and drains only when nothing replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            rr_ptr  <= '0;
            rsp_id  <= '0;
            rsp_sum <= '0;
            rsp_ovf <= 1'b0;
        end else if (issue_p0) begin
            state   <= FULL;
            rsp_id  <= grant_idx;
            rsp_sum <= sum_p0;
            rsp_ovf <= mag_ovf(a_p0, b_p0);
            rr_ptr  <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if ((state == FULL) && rsp_ready) begin
            state   <= EMPTY;
        end
    end
endmodule

// File: tb/tb_fixed_point_adder_arbiter.sv
// Directed bench for fixed_point_adder_arbiter with N=8 and NUM_REQ=4.
// Each scenario task drives its own stimulus and checks hand-computed values.

module tb_fixed_point_adder_arbiter;
    localparam int N       = 8;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*N-1:0] req_a;
    logic [NUM_REQ*N-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [N-1:0]         rsp_sum;
    logic                 rsp_ovf;

    int checks = 0;
    int errors = 0;

    fixed_point_adder_arbiter #(.N(N), .NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got running want finished");
        $fatal(1);
    end

    task automatic set_ops(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b0;
        req_a = '0; req_b = '0;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", rsp_id); end
        checks++; if (rsp_sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", rsp_sum); end
        checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", rsp_ovf); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr got %0d want 0", dut.rr_ptr); end
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req_valid = 4'b0100; set_ops(2, 8'h05, 8'h83); rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", rsp_valid); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_id got %0d want 2", rsp_id); end
        checks++; if (rsp_sum !== 8'h02) begin errors++; $display("FAIL single_sum got %h want 02", rsp_sum); end
        checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf got %b want 0", rsp_ovf); end
        checks++; if (dut.rr_ptr !== 2'd3) begin errors++; $display("FAIL single_ptr got %0d want 3", dut.rr_ptr); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_ops(i, 8'(i + 1), 8'h10);
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_ready !== (4'b0001 << (c % 4))) begin
                errors++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready, 4'b0001 << (c % 4));
            end
            if (c > 0) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 1) % 4) || rsp_sum !== 8'(8'h11 + (c - 1) % 4)) begin
                    errors++; $display("FAIL rr_rsp c=%0d got v=%b id=%0d sum=%h want v=1 id=%0d sum=%h",
                                       c, rsp_valid, rsp_id, rsp_sum, (c - 1) % 4, 8'h11 + (c - 1) % 4);
                end
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        checks++; if (rsp_id !== 2'd0 || rsp_sum !== 8'h11) begin errors++; $display("FAIL rr_last got id=%0d sum=%h want id=0 sum=11", rsp_id, rsp_sum); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req_valid = 4'b0010; set_ops(1, 8'h03, 8'h04);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready c=%0d got %b want 0000", c, req_ready); end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 8'h11 || dut.rr_ptr !== 2'd1) begin
                errors++; $display("FAIL bp_hold c=%0d got v=%b id=%0d sum=%h ptr=%0d want v=1 id=0 sum=11 ptr=1",
                                   c, rsp_valid, rsp_id, rsp_sum, dut.rr_ptr);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release got %b want 0010", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'h07) begin
            errors++; $display("FAIL bp_result got v=%b id=%0d sum=%h want v=1 id=1 sum=07", rsp_valid, rsp_id, rsp_sum);
        end
    endtask

    task automatic test_sign_cases();
        logic [N-1:0] va [6] = '{8'h70, 8'h85, 8'h80, 8'hFF, 8'h7F, 8'h83};
        logic [N-1:0] vb [6] = '{8'h20, 8'h05, 8'h80, 8'h81, 8'h00, 8'h05};
        logic [N-1:0] vs [6] = '{8'h10, 8'h00, 8'h80, 8'h80, 8'h7F, 8'h02};
        logic         vo [6] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
        rsp_ready = 1'b1;
        req_valid = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            set_ops(3, va[i], vb[i]);
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== vs[i] || rsp_ovf !== vo[i]) begin
                errors++; $display("FAIL sign_case i=%0d a=%h b=%h got v=%b id=%0d sum=%h ovf=%b want v=1 id=3 sum=%h ovf=%b",
                                   i, va[i], vb[i], rsp_valid, rsp_id, rsp_sum, rsp_ovf, vs[i], vo[i]);
            end
        end
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        req_valid = 4'b0100; set_ops(2, 8'h01, 8'h01); rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || dut.rr_ptr !== 2'd3) begin
            errors++; $display("FAIL mid_full got v=%b ptr=%0d want v=1 ptr=3", rsp_valid, dut.rr_ptr);
        end
        req_valid = 4'b1010; rsp_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b want 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_ready got %b want 0000", req_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_grant got %b want 0010", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'h07) begin
            errors++; $display("FAIL mid_result got v=%b id=%0d sum=%h want v=1 id=1 sum=07", rsp_valid, rsp_id, rsp_sum);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        logic [NUM_REQ-1:0] want;
        rsp_ready = 1'b1;
        set_ops(0, 8'h01, 8'h02);
        set_ops(3, 8'h04, 8'h08);
        for (int c = 0; c < 20; c++) begin
            req_valid = (c >= 10) ? 4'b1001 : 4'b0001;
            want = (c < 10) ? 4'b0001 : (((c - 10) % 2 == 0) ? 4'b1000 : 4'b0001);
            #1;
            checks++;
            if (req_ready !== want) begin
                errors++; $display("FAIL fair_grant c=%0d got %b want %b", c, req_ready, want);
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_sign_cases();
        test_reset_midstream();
        test_fairness();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
